// File: rtl/int_logic_pkg.sv
// Shared opcodes, default widths and the result record used by the logic-unit
// command sequencer and its result buffer.
package int_logic_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int TAG_W_DEF  = 4;

    localparam logic [2:0] OP_AND     = 3'b000;
    localparam logic [2:0] OP_NAND    = 3'b001;
    localparam logic [2:0] OP_OR      = 3'b010;
    localparam logic [2:0] OP_NOR     = 3'b011;
    localparam logic [2:0] OP_XOR     = 3'b100;
    localparam logic [2:0] OP_XNOR    = 3'b101;
    localparam logic [2:0] OP_NOT     = 3'b110;
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    // One buffered result; widths follow the package defaults.
    typedef struct packed {
        logic [TAG_W_DEF-1:0]  tag;
        logic                  err;
        logic [DATA_W_DEF-1:0] data;
    } res_t;

    function automatic logic is_legal(input logic [2:0] op);
        return op != OP_ILLEGAL;
    endfunction

endpackage

// File: rtl/int_logic_seq_if.sv
// Command, logic-unit and result signals of the sequencer grouped into one bundle.
interface int_logic_seq_if
    import int_logic_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TAG_W  = TAG_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [TAG_W-1:0]  cmd_tag;
    logic [DATA_W-1:0] cmd_opa;
    logic [DATA_W-1:0] cmd_opb;
    logic              alu_enable;
    logic [2:0]        alu_operation;
    logic [DATA_W-1:0] alu_opa;
    logic [DATA_W-1:0] alu_opb;
    logic [DATA_W-1:0] alu_out;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_err;
    logic              busy;

    modport slave (
        input  cmd_valid, cmd_op, cmd_tag, cmd_opa, cmd_opb, alu_out, res_ready,
        output cmd_ready, alu_enable, alu_operation, alu_opa, alu_opb,
               res_valid, res_data, res_tag, res_err, busy
    );

    modport master (
        output cmd_valid, cmd_op, cmd_tag, cmd_opa, cmd_opb, alu_out, res_ready,
        input  cmd_ready, alu_enable, alu_operation, alu_opa, alu_opb,
               res_valid, res_data, res_tag, res_err, busy
    );

endinterface

// File: rtl/int_logic_res_fifo.sv
// In-order circular result buffer with explicit occupancy count; push and pop
// may coincide at any fill level, and a pushed entry is visible the next cycle.
module int_logic_res_fifo #(
    parameter int  W     = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head_data,
    output logic          valid,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_next_s;
    logic          valid_r;

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next_s = count_r;
        case ({push, pop})
            2'b10:   count_next_s = count_r + CW'(1'b1);
            2'b01:   count_next_s = count_r - CW'(1'b1);
            default: count_next_s = count_r;
        endcase
    end

    // Storage, pointers and occupancy; contents are cleared so no stale entry leaks after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            valid_r  <= 1'b0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            count_r <= count_next_s;
            valid_r <= count_next_s != '0;
        end
    end

    assign head_data = mem_r[rd_ptr_r];
    assign valid     = valid_r;
    assign count     = count_r;

endmodule

// File: rtl/int_logic_seq_chk.sv
// Occupancy checks for the result buffer: never written when full without a
// matching read, never read when empty.
module int_logic_seq_chk #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (count == CW'(DEPTH))))
        else $error("result fifo overflow");

    a_no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && (count == '0)))
        else $error("result fifo underflow");

endmodule

// File: rtl/int_logic_seq.sv
// Issues tagged logic commands to the logic unit one per cycle, tracks them for
// the unit's latency and returns results in order through a credit-protected FIFO.
module int_logic_seq
    import int_logic_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int LAT       = 1,
    parameter int RES_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    int_logic_seq_if.slave bus
);
    localparam int CW = $clog2(RES_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             err;
    } trk_t;

    trk_t              trk_r [LAT+1];
    logic [CW-1:0]     credit_r;
    logic [CW-1:0]     credit_next_s;
    logic [CW-1:0]     fifo_count_s;
    logic              cmd_ready_r;
    logic              busy_r;
    logic              alu_enable_r;
    logic [2:0]        alu_operation_r;
    logic [DATA_W-1:0] alu_opa_r;
    logic [DATA_W-1:0] alu_opb_r;
    logic              accept_s;
    logic              pop_s;
    logic              push_s;
    logic              res_valid_s;
    res_t              push_rec_s;
    res_t              head_rec_s;

    assign accept_s = bus.cmd_valid & cmd_ready_r;
    assign pop_s    = res_valid_s & bus.res_ready;
    assign push_s   = trk_r[LAT].valid;

    // Credits cover both in-flight slots and buffered results, so a push can never find the FIFO full.
    always_comb begin
        credit_next_s = credit_r;
        case ({accept_s, pop_s})
            2'b10:   credit_next_s = credit_r + CW'(1'b1);
            2'b01:   credit_next_s = credit_r - CW'(1'b1);
            default: credit_next_s = credit_r;
        endcase
    end

    // Credit count with ready/busy registered from it, so neither depends on res_ready combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_r    <= '0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            credit_r    <= credit_next_s;
            cmd_ready_r <= credit_next_s < CW'(RES_DEPTH);
            busy_r      <= credit_next_s != '0;
        end
    end

    // Issue strobe; operand pins only move for legal commands and otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_enable_r    <= 1'b0;
            alu_operation_r <= 3'b000;
            alu_opa_r       <= '0;
            alu_opb_r       <= '0;
        end else begin
            alu_enable_r <= accept_s && is_legal(bus.cmd_op);
            if (accept_s && is_legal(bus.cmd_op)) begin
                alu_operation_r <= bus.cmd_op;
                alu_opa_r       <= bus.cmd_opa;
                alu_opb_r       <= bus.cmd_opb;
            end
        end
    end

    // Tag/err tracking pipeline; the last stage lines up with the cycle alu_out is valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= LAT; k++) begin
                trk_r[k] <= '0;
            end
        end else begin
            trk_r[0] <= '{valid: accept_s, tag: bus.cmd_tag, err: !is_legal(bus.cmd_op)};
            for (int k = 1; k <= LAT; k++) begin
                trk_r[k] <= trk_r[k-1];
            end
        end
    end

    // Result record entering the buffer; illegal slots carry zero data.
    always_comb begin
        push_rec_s.tag = trk_r[LAT].tag;
        push_rec_s.err = trk_r[LAT].err;
        if (trk_r[LAT].err) begin
            push_rec_s.data = '0;
        end else begin
            push_rec_s.data = bus.alu_out;
        end
    end

    int_logic_res_fifo #(
        .W     ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_rec_s),
        .pop       (pop_s),
        .head_data (head_rec_s),
        .valid     (res_valid_s),
        .count     (fifo_count_s)
    );

    int_logic_seq_chk #(
        .DEPTH (RES_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (fifo_count_s)
    );

    assign bus.cmd_ready     = cmd_ready_r;
    assign bus.busy          = busy_r;
    assign bus.alu_enable    = alu_enable_r;
    assign bus.alu_operation = alu_operation_r;
    assign bus.alu_opa       = alu_opa_r;
    assign bus.alu_opb       = alu_opb_r;
    assign bus.res_valid     = res_valid_s;
    assign bus.res_data      = head_rec_s.data;
    assign bus.res_tag       = head_rec_s.tag;
    assign bus.res_err       = head_rec_s.err;

endmodule

// File: tb/tb_int_logic_seq.sv
// Bench for int_logic_seq: a registered logic-unit model, vector table, directed
// corner sequences and random traffic against an in-order expected-result queue.
module tb_int_logic_seq;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   tcnt  = 0;

    int_logic_seq_if #(.DATA_W(64), .TAG_W(4)) bus ();

    int_logic_seq #(.DATA_W(64), .TAG_W(4), .LAT(1), .RES_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) tcnt <= tcnt + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return ~(a & b);
            3'd2:    return a | b;
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return 64'd0;
        endcase
    endfunction

    // Logic unit with one cycle of latency.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.alu_out <= 64'd0;
        else if (bus.alu_enable) bus.alu_out <= ref_calc(bus.alu_operation, bus.alu_opa, bus.alu_opb);
    end

    // Expected results: one entry per accepted command, in acceptance order.
    typedef struct {
        logic [3:0]  tag;
        logic        err;
        logic [63:0] data;
        int          cyc;
    } exp_t;

    exp_t        q[$];
    logic        mon_en   = 1'b0;
    logic        last_acc = 1'b0;
    int          acc_cnt  = 0;
    int          cyc      = 0;
    logic        prev_leg = 1'b0;
    logic [2:0]  hold_op  = 3'd0;
    logic [63:0] hold_a   = 64'd0;
    logic [63:0] hold_b   = 64'd0;

    // Mid-cycle monitor: credit, busy, exact result timing, issue pins and result content.
    always @(negedge clk) begin
        logic exp_rv;
        logic acc;
        exp_t e;
        if (rst) begin
            q.delete();
            prev_leg = 1'b0;
            hold_op  = 3'd0;
            hold_a   = 64'd0;
            hold_b   = 64'd0;
            cyc      = 0;
            last_acc = 1'b0;
        end else if (mon_en) begin
            cyc++;
            chk("cmd_ready", bus.cmd_ready, q.size() < 4);
            chk("busy", bus.busy, q.size() != 0);
            exp_rv = 1'b0;
            if (q.size() != 0) exp_rv = cyc >= q[0].cyc + 3;
            chk("res_valid", bus.res_valid, exp_rv);
            chk("alu_enable", bus.alu_enable, prev_leg);
            chk("alu_operation", bus.alu_operation, hold_op);
            chk("alu_opa", bus.alu_opa, hold_a);
            chk("alu_opb", bus.alu_opb, hold_b);
            if (bus.res_valid && q.size() != 0) begin
                chk("res_data", bus.res_data, q[0].data);
                chk("res_tag", bus.res_tag, q[0].tag);
                chk("res_err", bus.res_err, q[0].err);
                if (bus.res_ready) void'(q.pop_front());
            end
            acc      = bus.cmd_valid && bus.cmd_ready;
            prev_leg = 1'b0;
            if (acc) begin
                e.tag  = bus.cmd_tag;
                e.err  = bus.cmd_op == 3'b111;
                e.data = ref_calc(bus.cmd_op, bus.cmd_opa, bus.cmd_opb);
                e.cyc  = cyc;
                q.push_back(e);
                if (bus.cmd_op != 3'b111) begin
                    prev_leg = 1'b1;
                    hold_op  = bus.cmd_op;
                    hold_a   = bus.cmd_opa;
                    hold_b   = bus.cmd_opb;
                end
                acc_cnt++;
            end
            last_acc = acc;
        end
    end

    task automatic send(input logic [2:0] op, input logic [3:0] tag, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_tag   = tag;
        bus.cmd_opa   = a;
        bus.cmd_opb   = b;
        @(negedge clk);
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("send_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_res(output logic [63:0] d, output logic [3:0] t, output logic e, output int at);
        int n = 0;
        @(negedge clk);
        while (!(bus.res_valid && bus.res_ready) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk("res_timeout", 64'd1, 64'd0);
        d  = bus.res_data;
        t  = bus.res_tag;
        e  = bus.res_err;
        at = tcnt;
        @(posedge clk);
        #1;
    endtask

    task automatic new_payload();
        bus.cmd_op  = 3'($urandom_range(0, 7));
        bus.cmd_tag = 4'($urandom_range(0, 15));
        bus.cmd_opa = {$urandom, $urandom};
        bus.cmd_opb = {$urandom, $urandom};
    endtask

    task automatic drain();
        int n = 0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        while (q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ctrl"}, {bus.cmd_ready, bus.alu_enable, bus.res_valid, bus.res_err, bus.busy,
                            bus.alu_operation, bus.res_tag}, 64'd0);
        chk({nm, "_opa"}, bus.alu_opa, 64'd0);
        chk({nm, "_opb"}, bus.alu_opb, 64'd0);
        chk({nm, "_data"}, bus.res_data, 64'd0);
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [3:0]  tag;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t vt[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d;
        logic [3:0]  t;
        logic        e;
        int          at0, at1, at2, a0;

        vt[0] = '{3'b000, 4'd3,  64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F, 64'h0F0F00000F0F0000, 1'b0};
        vt[1] = '{3'b001, 4'd4,  64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFF00000000, 64'h00000000FFFFFFFF, 1'b0};
        vt[2] = '{3'b010, 4'd5,  64'h00FF00FF00FF00FF, 64'h0F000000000000F0, 64'h0FFF00FF00FF00FF, 1'b0};
        vt[3] = '{3'b011, 4'd6,  64'h0000000000000000, 64'h0000000000000000, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[4] = '{3'b100, 4'd7,  64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vt[5] = '{3'b101, 4'd8,  64'hF0F0F0F0F0F0F0F0, 64'hFF00FF00FF00FF00, 64'hF00FF00FF00FF00F, 1'b0};
        vt[6] = '{3'b110, 4'd10, 64'h0123456789ABCDEF, 64'h5A5A5A5A5A5A5A5A, 64'hFEDCBA9876543210, 1'b0};
        vt[7] = '{3'b111, 4'd9,  64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 64'h0000000000000000, 1'b1};

        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_tag   = 4'd0;
        bus.cmd_opa   = 64'd0;
        bus.cmd_opb   = 64'd0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_all_zero("reset");
        #1 rst = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;

        // Single AND: enable one cycle after accept, result two cycles later.
        send(3'b000, 4'd3, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F);
        chk("t1_en_c1", bus.alu_enable, 1'b1);
        chk("t1_rv_c1", bus.res_valid, 1'b0);
        @(posedge clk);
        #1 chk("t1_en_c2", bus.alu_enable, 1'b0);
        chk("t1_rv_c2", bus.res_valid, 1'b0);
        @(posedge clk);
        #1 chk("t1_rv_c3", bus.res_valid, 1'b1);
        chk("t1_data", bus.res_data, 64'h0F0F00000F0F0000);
        chk("t1_tag", bus.res_tag, 4'd3);
        chk("t1_err", bus.res_err, 1'b0);
        drain();

        // Vector table, one command at a time.
        bus.res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(vt[i].op, vt[i].tag, vt[i].a, vt[i].b);
            wait_res(d, t, e, at0);
            chk($sformatf("vec%0d_data", i), d, vt[i].exp_d);
            chk($sformatf("vec%0d_tag", i), t, vt[i].tag);
            chk($sformatf("vec%0d_err", i), e, vt[i].exp_e);
        end
        drain();

        // Back-to-back XOR, NOR, OR; results must be consecutive and in order.
        bus.res_ready = 1'b1;
        send(3'b100, 4'd1, 64'hAAAAAAAAAAAAAAAA, 64'h5555555555555555);
        send(3'b011, 4'd2, 64'd0, 64'd0);
        send(3'b010, 4'd3, 64'h00FF00FF00FF00FF, 64'h0F000000000000F0);
        wait_res(d, t, e, at0);
        chk("b2b_d0", d, 64'hFFFFFFFFFFFFFFFF);
        chk("b2b_t0", t, 4'd1);
        wait_res(d, t, e, at1);
        chk("b2b_d1", d, 64'hFFFFFFFFFFFFFFFF);
        chk("b2b_t1", t, 4'd2);
        wait_res(d, t, e, at2);
        chk("b2b_d2", d, 64'h0FFF00FF00FF00FF);
        chk("b2b_t2", t, 4'd3);
        chk("b2b_gap01", 64'(at1 - at0), 64'd1);
        chk("b2b_gap12", 64'(at2 - at1), 64'd1);
        drain();

        // Illegal opcode between two ANDs.
        bus.res_ready = 1'b1;
        send(3'b000, 4'd1, 64'hFFFF0000FFFF0000, 64'h0F0F0F0F0F0F0F0F);
        send(3'b111, 4'd9, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        send(3'b000, 4'd2, 64'hFFFFFFFFFFFFFFFF, 64'h123456789ABCDEF0);
        wait_res(d, t, e, at0);
        chk("ill_t0", t, 4'd1);
        chk("ill_d0", d, 64'h0F0F00000F0F0000);
        wait_res(d, t, e, at0);
        chk("ill_t1", t, 4'd9);
        chk("ill_d1", d, 64'd0);
        chk("ill_e1", e, 1'b1);
        wait_res(d, t, e, at0);
        chk("ill_t2", t, 4'd2);
        chk("ill_d2", d, 64'h123456789ABCDEF0);
        chk("ill_e2", e, 1'b0);
        drain();

        // Backpressure: exactly four accepts, one pop frees one credit the next cycle.
        bus.res_ready = 1'b0;
        a0 = acc_cnt;
        new_payload();
        bus.cmd_valid = 1'b1;
        repeat (8) begin
            @(posedge clk);
            #1 if (last_acc) new_payload();
        end
        chk("bp_accepts4", 64'(acc_cnt - a0), 64'd4);
        chk("bp_ready_low", bus.cmd_ready, 1'b0);
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
        chk("bp_ready_back", bus.cmd_ready, 1'b1);
        @(posedge clk);
        #1 chk("bp_accepts5", 64'(acc_cnt - a0), 64'd5);
        new_payload();
        repeat (3) @(posedge clk);
        #1 chk("bp_accepts5_hold", 64'(acc_cnt - a0), 64'd5);
        drain();

        // Asynchronous reset with two buffered and two in flight.
        bus.res_ready = 1'b0;
        send(3'b010, 4'd11, 64'h1111, 64'h2222);
        send(3'b100, 4'd12, 64'h3333, 64'h4444);
        repeat (4) @(posedge clk);
        #1 send(3'b000, 4'd13, 64'hFFFF, 64'h0F0F);
        send(3'b101, 4'd14, 64'h5555, 64'hAAAA);
        #1 mon_en = 1'b0;
        rst = 1'b1;
        #1 chk_all_zero("async_rst");
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        bus.res_ready = 1'b1;
        send(3'b000, 4'd5, 64'hFFFF0000FFFF0000, 64'h00FF00FF00FF00FF);
        wait_res(d, t, e, at0);
        chk("post_rst_tag", t, 4'd5);
        chk("post_rst_data", d, 64'h00FF000000FF0000);
        repeat (4) @(posedge clk);
        #1 chk("post_rst_rv", bus.res_valid, 1'b0);
        chk("post_rst_busy", bus.busy, 1'b0);

        // Random traffic: mostly-stalled consumer first (full FIFO), then mostly-ready.
        bus.cmd_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (c < 1500) bus.res_ready = $urandom_range(0, 3) == 0;
            else          bus.res_ready = $urandom_range(0, 3) != 0;
            if (!bus.cmd_valid || last_acc) begin
                bus.cmd_valid = $urandom_range(0, 3) != 0;
                new_payload();
            end
            @(posedge clk);
            #1;
        end
        drain();
        chk("final_busy", bus.busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
